conv_window_mac: RTL and testbench

Multiply-accumulate stage directly downstream of the activation loader. Takes the 3x3 activation window (three 24-bit rows) with a one-cycle valid pulse, forms a signed dot product with a matching 3x3 weight window, and accumulates across `channel` input channels. Adds bias, applies optional ReLU, and presents one output pixel through a valid/ready register. The loader's `done` drives `act_valid`; `in_ready` gates the loader's next `load_start`.

---
 rtl/conv_window_mac.sv | 104 ++++++++++
 tb/tb_conv_window_mac.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_mac.sv
// 3x3 signed dot-product MAC: unsigned activations times signed weights, accumulated
// over a channel group, then bias and optional ReLU into a valid/ready output register.
module conv_window_mac #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [11:0]                   channel,
    input  logic                          relu_en,
    input  logic signed [ACC_WIDTH-1:0]   bias,
    input  logic                          act_valid,
    input  logic [3*WEIGHT_WIDTH-1:0]     activate0,
    input  logic [3*WEIGHT_WIDTH-1:0]     activate1,
    input  logic [3*WEIGHT_WIDTH-1:0]     activate2,
    input  logic [3*WEIGHT_WIDTH-1:0]     weight0,
    input  logic [3*WEIGHT_WIDTH-1:0]     weight1,
    input  logic [3*WEIGHT_WIDTH-1:0]     weight2,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [ACC_WIDTH-1:0]          out_data,
    input  logic                          out_ready
);
    localparam int W  = WEIGHT_WIDTH;
    localparam int PW = 2*W + 1;   // unsigned W x signed W product
    localparam int SW = PW + 4;    // headroom for 9 terms

    logic [9*W-1:0] act_flat, wgt_flat;
    assign act_flat = {activate2, activate1, activate0};
    assign wgt_flat = {weight2, weight1, weight0};

    logic signed [PW-1:0] prod_d [9];
    logic signed [PW-1:0] prod_q [9];
    logic signed [SW-1:0] sum_d, sum_q;

    // Row/byte pairing is purely positional, so the flattened byte index pairs correctly.
    for (genvar g = 0; g < 9; g++) begin : g_mul
        assign prod_d[g] = $signed({1'b0, act_flat[g*W +: W]}) * $signed(wgt_flat[g*W +: W]);
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++)
            sum_d = sum_d + {{(SW-PW){prod_q[i][PW-1]}}, prod_q[i]};
    end

    logic [11:0]                 ccnt, ch_lat, ch_eff, cur_ch;
    logic                        is_last, accept, last_pending;
    logic [1:0]                  vld_pipe, last_pipe, relu_pipe;
    logic signed [ACC_WIDTH-1:0] bias_pipe [2];
    logic signed [ACC_WIDTH-1:0] acc, sum_ext, res;

    assign in_ready = ~last_pending & ~out_valid;
    assign accept   = act_valid & in_ready;
    assign ch_eff   = (channel == 12'd0) ? 12'd1 : channel;
    // The group size is taken live on the first window and held for the rest of the group.
    assign cur_ch   = (ccnt == 12'd0) ? ch_eff : ch_lat;
    assign is_last  = (ccnt == cur_ch - 12'd1);
    assign sum_ext  = {{(ACC_WIDTH-SW){sum_q[SW-1]}}, sum_q};
    assign res      = acc + sum_ext + bias_pipe[1];

    // Datapath registers carry no reset; only their valid bits matter.
    always_ff @(posedge clk) begin
        prod_q       <= prod_d;
        sum_q        <= sum_d;
        relu_pipe    <= {relu_pipe[0], relu_en};
        bias_pipe[0] <= bias;
        bias_pipe[1] <= bias_pipe[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ccnt         <= '0;
            ch_lat       <= '0;
            last_pending <= 1'b0;
            vld_pipe     <= '0;
            last_pipe    <= '0;
            acc          <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[0], accept};
            last_pipe <= {last_pipe[0], accept & is_last};
            if (accept) begin
                if (ccnt == 12'd0) ch_lat <= ch_eff;
                ccnt <= is_last ? 12'd0 : ccnt + 12'd1;
                if (is_last) last_pending <= 1'b1;
            end
            if (out_valid && out_ready) begin
                out_valid    <= 1'b0;
                last_pending <= 1'b0;
            end
            if (vld_pipe[1]) begin
                if (last_pipe[1]) begin
                    out_data  <= (relu_pipe[1] && res[ACC_WIDTH-1]) ? '0 : res;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc + sum_ext;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_window_mac.sv
// Randomised + directed bench for conv_window_mac with a queue scoreboard and a
// behavioural dot-product/accumulate model.
module tb_conv_window_mac;
    logic               clk = 1'b0;
    logic               rst;
    logic [11:0]        channel;
    logic               relu_en;
    logic signed [31:0] bias;
    logic               act_valid;
    logic [23:0]        activate0, activate1, activate2;
    logic [23:0]        weight0, weight1, weight2;
    logic               in_ready, out_valid, out_ready;
    logic [31:0]        out_data;

    conv_window_mac dut (
        .clk(clk), .rst(rst), .channel(channel), .relu_en(relu_en), .bias(bias),
        .act_valid(act_valid),
        .activate0(activate0), .activate1(activate1), .activate2(activate2),
        .weight0(weight0), .weight1(weight1), .weight2(weight2),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int                 n_chk = 0;
    int                 n_fail = 0;
    logic [31:0]        exp_q[$];
    int                 m_cnt = 0;
    int                 m_ch = 1;
    logic signed [31:0] m_acc = 0;
    bit                 rand_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every output handshake must match the next modelled pixel.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none at %0t", out_data, $time);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    function automatic logic signed [31:0] dot(input logic [71:0] a, input logic [71:0] w);
        int s = 0;
        for (int i = 0; i < 9; i++) begin
            logic [7:0]        ab;
            logic signed [7:0] wb;
            ab = a[i*8 +: 8];
            wb = w[i*8 +: 8];
            s += int'(ab) * int'(wb);
        end
        return s;
    endfunction

    function automatic logic [71:0] fill(input logic [7:0] b);
        return {9{b}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [71:0] a, input logic [71:0] w, input logic [11:0] ch,
                        input logic [31:0] b, input bit r);
        int g = 0;
        logic signed [31:0] res;
        while (!in_ready && g < 300) begin
            step();
            g++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
            return;
        end
        {activate2, activate1, activate0} = a;
        {weight2, weight1, weight0}       = w;
        channel   = ch;
        bias      = b;
        relu_en   = r;
        act_valid = 1'b1;
        if (m_cnt == 0) m_ch = (ch == 0) ? 1 : int'(ch);
        m_acc = m_acc + dot(a, w);
        m_cnt++;
        if (m_cnt == m_ch) begin
            res = m_acc + $signed(b);
            exp_q.push_back((r && res < 0) ? 32'd0 : res);
            m_acc = 0;
            m_cnt = 0;
        end
        step();
        act_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 400) begin
            step();
            g++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; channel = 12'd1; relu_en = 1'b0; bias = 0; act_valid = 1'b0;
        {activate2, activate1, activate0} = '0;
        {weight2, weight1, weight0} = '0;
        out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        step();

        // Single channel latency and in_ready window
        send(fill(8'd1), fill(8'd1), 12'd1, 0, 0);
        check("t1_in_ready", in_ready, 0);
        check("t1_out_valid", out_valid, 0);
        step();
        check("t2_in_ready", in_ready, 0);
        check("t2_out_valid", out_valid, 0);
        step();
        check("t3_out_valid", out_valid, 1);
        check("t3_out_data", out_data, 32'd9);
        check("t3_in_ready", in_ready, 0);
        step();
        check("t4_out_valid", out_valid, 0);
        check("t4_in_ready", in_ready, 1);

        // Signed extreme with and without ReLU
        send(fill(8'hFF), fill(8'h80), 12'd1, 0, 0);
        send(fill(8'hFF), fill(8'h80), 12'd1, 0, 1);
        drain();

        // Accumulation across 3 channels, twice
        repeat (2) begin
            send({64'd0, 8'd10}, {64'd0, 8'd1},   12'd3, 5, 0);
            send({64'd0, 8'd1},  {64'd0, 8'hFC},  12'd3, 5, 0);
            send({64'd0, 8'd7},  {64'd0, 8'd1},   12'd3, 5, 0);
        end
        drain();

        // Byte pairing
        send({48'd0, 8'd3, 16'd0}, {48'd0, 8'd2, 16'd0}, 12'd1, 0, 0);
        send({48'd0, 8'd3, 16'd0}, {64'd0, 8'd2},        12'd1, 0, 0);
        drain();

        // Backpressure: output must hold, stray windows ignored
        out_ready = 1'b0;
        send(fill(8'd2), fill(8'd3), 12'd1, 7, 0);
        begin
            int g = 0;
            while (!out_valid && g < 20) begin step(); g++; end
        end
        check("bp_valid_rise", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            act_valid = i[0];
            {activate2, activate1, activate0} = fill(8'd5);
            step();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 32'd61);
            check("bp_in_ready", in_ready, 0);
        end
        act_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_valid_fall", out_valid, 0);
        check("bp_in_ready_rise", in_ready, 1);
        send(fill(8'd1), fill(8'hFF), 12'd1, -3, 0);
        drain();

        // Reset in the middle of a group
        send(fill(8'd1), fill(8'd1), 12'd4, 0, 0);
        send(fill(8'd1), fill(8'd1), 12'd4, 0, 0);
        rst = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        step();
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data", out_data, 0);
        check("mrst_in_ready", in_ready, 1);
        rst = 1'b0;
        step();
        send(fill(8'd1), fill(8'd1), 12'd1, 0, 0);
        drain();

        // Random groups; channel on non-first windows is noise the DUT must ignore
        rand_mode = 1;
        for (int gi = 0; gi < 40; gi++) begin
            int ch, n;
            logic [31:0] b;
            bit r;
            ch = $urandom_range(0, 4);
            n  = (ch == 0) ? 1 : ch;
            b  = $urandom;
            r  = $urandom_range(0, 1);
            for (int k = 0; k < n; k++) begin
                send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                     (k == 0) ? 12'(ch) : 12'($urandom_range(0, 15)), b, r);
                if ($urandom_range(0, 3) == 0) step();
            end
        end
        rand_mode = 0;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
